reg_file_2r1w: RTL
==================

# reg_file_2r1w

Parametrised register file with one synchronous write port and two independent registered read ports. Each read port selects one of DEPTH entries through an internal DEPTH-to-1 selector and presents the result one clock later with a valid strobe. It is the storage block behind the datapath's operand fetch and generalises the fixed eight-entry, 32-bit selection path to arbitrary width and depth, adding storage, read enables, an optional hardwired zero entry and optional write-to-read bypass.

## Interface
- WIDTH, 32, data width in bits (1..64)
- DEPTH, 8, number of entries; power of two, 2..32
- AW, 3, address width; must equal log2(DEPTH)
- ZERO_REG, 0, if 1 entry 0 always reads zero and ignores writes
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- we  input  1  write enable
- wr_addr  input  AW  write address
- wr_data  input  WIDTH  write data
- re_a  input  1  port A read enable
- rd_addr_a  input  AW  port A read address
- re_b  input  1  port B read enable
- rd_addr_b  input  AW  port B read address
- rd_data_a  output  WIDTH  port A registered read data
- rd_valid_a  output  1  port A data valid, one-cycle pulse per read
- rd_data_b  output  WIDTH  port B registered read data
- rd_valid_b  output  1  port B data valid

## Operation
- Reset (reset_n low, asynchronous): all DEPTH entries, rd_data_a, rd_data_b = 0; rd_valid_a, rd_valid_b = 0. Held while reset_n low. Any in-flight read is dropped.
- Write: at the rising edge with we=1, entry[wr_addr] <= wr_data. If ZERO_REG=1 and wr_addr=0, the write is discarded.
- Read, per port X in {a,b}, independent:
  - At the edge with re_X=1: rd_data_X <= entry[rd_addr_X]; rd_valid_X <= 1.
  - At the edge with re_X=0: rd_data_X holds its last value; rd_valid_X <= 0.
  - ZERO_REG=1 and rd_addr_X=0: captured value is 0.
- Both ports may read the same address in the same cycle; both receive identical data.
- Same-cycle read and write of the same address: result is set by Configuration.
- No address range check is needed: DEPTH = 2^AW, so every address is valid.

## Timing
- Write latency: data is visible to a read issued on the cycle after the write edge.
- Read latency: 1 cycle. The address and re sampled at edge N produce rd_data/rd_valid after edge N.
- Back-to-back reads are allowed every cycle on both ports; rd_valid stays high across consecutive reads.
- Outputs are fully registered; there is no combinational path from inputs to outputs.
- When reset_n is released, the first edge with re_X=1 produces valid data; there is no warm-up cycle.

## Configuration
- RF_WR_BYPASS_EN:
  - Defined: at an edge with we=1, re_X=1 and rd_addr_X == wr_addr, port X captures wr_data rather than the old entry. Exception: with ZERO_REG=1 and address 0, the port still returns 0.
  - Undefined: port X captures the pre-write contents. The new value is returned from the next cycle onward.
- The macro affects only the capture mux. Storage and write behaviour are identical in both builds.

## Test plan
- Reset: drive reset_n low mid-stream after writing 0xDEADBEEF to entry 5. Release it, then read entry 5 on port A. Required: rd_data_a = 0; rd_valid_a = 0 during reset and 1 one cycle after the read.
- Write/read all entries: write entry i = 0x1000_0000 + i for i = 0..7, then read i on port A and 7-i on port B each cycle. Required: each value appears exactly one cycle after its address; rd_valid is high continuously.
- Hold on idle: read entry 3 (0x1000_0003), then hold re_a = 0 for 3 cycles while changing rd_addr_a. Required: rd_data_a stays 0x1000_0003; rd_valid_a = 0.
- Collision: entry 2 = 0x11, then write 0x22 to entry 2 while reading 2 on both ports. Required: 0x22 with RF_WR_BYPASS_EN defined, 0x11 without; a read on the following cycle returns 0x22 in both builds.
- ZERO_REG=1: write 0xFFFF_FFFF to entry 0 while reading entry 0. Required: 0 on both ports in both builds; a later read of entry 0 also returns 0.
- Parameter sweep: WIDTH=8, DEPTH=32. Write 0xA5 to entry 31 and read it on port B. Required: rd_data_b = 0xA5 one cycle after the read.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with registered read ports and valid strobes.
// Define RF_WR_BYPASS_EN to forward same-cycle write data to a colliding read.
module reg_file_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             re_a,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic             re_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_valid_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_b_q;
  logic [WIDTH-1:0] rd_data_a_d, rd_data_b_d;
  logic             rd_valid_a_q, rd_valid_b_q;
  logic             wr_en;

  // Entry 0 never takes a write when it is hardwired to zero.
  assign wr_en = we && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a_d = '0;
    rd_data_b_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_a == AW'(i)) rd_data_a_d = mem_q[i];
      if (rd_addr_b == AW'(i)) rd_data_b_d = mem_q[i];
    end
`ifdef RF_WR_BYPASS_EN
    if (we && (wr_addr == rd_addr_a)) rd_data_a_d = wr_data;
    if (we && (wr_addr == rd_addr_b)) rd_data_b_d = wr_data;
`endif
    // The zero override wins over bypass as well as over storage.
    if ((ZERO_REG != 0) && (rd_addr_a == '0)) rd_data_a_d = '0;
    if ((ZERO_REG != 0) && (rd_addr_b == '0)) rd_data_b_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
    end else begin
      rd_valid_a_q <= re_a;
      rd_valid_b_q <= re_b;
      if (re_a) rd_data_a_q <= rd_data_a_d;
      if (re_b) rd_data_b_q <= rd_data_b_d;
    end
  end

  assign rd_data_a  = rd_data_a_q;
  assign rd_data_b  = rd_data_b_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_valid_b = rd_valid_b_q;

endmodule
